// File: rtl/mem_stage_requester.sv
// MEM-stage memory requester: turns the pipeline's load/store enables into a
// req/ack transaction on a multi-cycle word memory, stalling the pipeline via
// `ready` until the access completes, is rejected as out of range, or times out.
module mem_stage_requester #(
    parameter int unsigned BASE_ADDR  = 1024,
    parameter int unsigned WORD_COUNT = 64,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        ready,
    output logic [31:0] rdata_out,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    // Last WAIT count before the access is given up on (TIMEOUT is 1..255).
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        active;
    logic [31:0] word_index;
    logic        out_of_range;

    // Request decode and byte-address to word-index translation; the low two
    // address bits are dropped by the shift, and addresses below the base are
    // caught separately because the subtraction would wrap.
    always_comb begin
        active       = mem_r_en | mem_w_en;
        word_index   = (addr_in - BASE_ADDR) >> 2;
        out_of_range = (addr_in < BASE_ADDR) || (word_index >= WORD_COUNT);
    end

    // Register update; reset overrides any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic; everything holds unless a transition says otherwise,
    // which keeps the memory-side fields stable for the whole request.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (active) begin
                    if (out_of_range) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = S_DONE;
                    end else begin
                        mem_addr_d  = word_index;
                        mem_wdata_d = wdata_in;
                        mem_we_d    = mem_w_en;
                        mem_req_d   = 1'b1;
                        cnt_d       = 8'd0;
                        state_d     = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (!mem_we_q) begin
                        rdata_d = 32'd0;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The pipeline may advance when nothing is pending or an access just finished.
    always_comb begin
        ready = ((state_q == S_IDLE) && !active) || (state_q == S_DONE);
    end

    assign rdata_out = rdata_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_stage_requester.sv
// Testbench for mem_stage_requester: a table of accesses run against a small
// word-memory responder, with expected completions queued as a scoreboard,
// plus hand-written back-to-back, late-ack and mid-access reset sequences.
module tb_mem_stage_requester;

    localparam int TIMEOUT_CYCLES = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        ready;
    logic [31:0] rdata_out;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        r_en;
        logic        w_en;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_delay;    // ack in the n-th cycle of mem_req, 0 = never
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic        exp_we;
        logic [31:0] exp_idx;
        int          exp_stall;    // cycles from request to DONE
        int          exp_req_cycles;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          stall;
        int          req_cycles;
    } exp_t;

    vec_t        vecs[14];
    exp_t        sb_q[$];
    logic [31:0] model[64];
    int          total = 0;
    int          bad   = 0;

    mem_stage_requester #(
        .BASE_ADDR (1024),
        .WORD_COUNT(64),
        .TIMEOUT   (TIMEOUT_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_r_en (mem_r_en),
        .mem_w_en (mem_w_en),
        .addr_in  (addr_in),
        .wdata_in (wdata_in),
        .ready    (ready),
        .rdata_out(rdata_out),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r_en, input logic w_en,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        mem_r_en = r_en;
        mem_w_en = w_en;
        addr_in  = addr;
        wdata_in = wdata;
    endtask

    // Runs one access from its IDLE cycle to its DONE cycle, acting as the
    // memory. At DONE either drops the enables or presents next_v.
    task automatic doAccess(input vec_t v, input bit present_next, input vec_t next_v);
        int   cyc      = 0;
        int   req_cnt  = 0;
        bit   done     = 0;
        exp_t e;
        exp_t got;
        @(negedge clk);
        applyStimulus(v.r_en, v.w_en, v.addr, v.wdata);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        e.err        = v.exp_err;
        e.rdata      = v.exp_rdata;
        e.stall      = v.exp_stall;
        e.req_cycles = v.exp_req_cycles;
        sb_q.push_back(e);
        #1;
        checkOutput("idle_mem_req", mem_req, 0);
        checkOutput("idle_ready", ready, 0);
        checkOutput("idle_err", err, 0);
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (ready) begin
                done = 1;
                checkOutput("done_mem_req", mem_req, 0);
                if (sb_q.size() == 0) begin
                    checkOutput("sb_empty", 1, 0);
                end else begin
                    got = sb_q.pop_front();
                    checkOutput("done_err", err, got.err);
                    checkOutput("done_rdata", rdata_out, got.rdata);
                    checkOutput("stall_cycles", cyc, got.stall);
                    checkOutput("req_cycles", req_cnt, got.req_cycles);
                end
                if (present_next)
                    applyStimulus(next_v.r_en, next_v.w_en, next_v.addr, next_v.wdata);
                else
                    applyStimulus(0, 0, 32'd0, 32'd0);
            end else if (mem_req) begin
                req_cnt++;
                checkOutput("mem_we", mem_we, v.exp_we);
                checkOutput("mem_addr", mem_addr, v.exp_idx);
                if (v.exp_we)
                    checkOutput("mem_wdata", mem_wdata, v.wdata);
                if (v.ack_delay != 0 && req_cnt == v.ack_delay && mem_addr < 64) begin
                    mem_ack = 1'b1;
                    if (mem_we)
                        model[mem_addr[5:0]] = mem_wdata;
                    else
                        mem_rdata = model[mem_addr[5:0]];
                end
            end
        end
        if (!done) begin
            checkOutput("done_reached", 0, 1);
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        vec_t none;
        vec_t rd_a;
        vec_t rd_b;
        none = '{0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 0, 32'd0, 0, 0};

        // r, w, addr, wdata, ack, err, rdata, we, idx, stall, req
        vecs[0]  = '{1, 0, 32'd1036, 32'd0,           3, 0, 32'hDEADBEEF, 0, 32'd3,  4,  3};
        vecs[1]  = '{0, 1, 32'd1028, 32'h12345678,    1, 0, 32'hDEADBEEF, 1, 32'd1,  2,  1};
        vecs[2]  = '{1, 0, 32'd1028, 32'd0,           2, 0, 32'h12345678, 0, 32'd1,  3,  2};
        vecs[3]  = '{1, 0, 32'd1280, 32'd0,           1, 1, 32'd0,        0, 32'd0,  1,  0};
        vecs[4]  = '{1, 0, 32'd1020, 32'd0,           1, 1, 32'd0,        0, 32'd0,  1,  0};
        vecs[5]  = '{1, 0, 32'd1028, 32'd0,           1, 0, 32'h12345678, 0, 32'd1,  2,  1};
        vecs[6]  = '{1, 1, 32'd1032, 32'hA5A5A5A5,    2, 0, 32'h12345678, 1, 32'd2,  3,  2};
        vecs[7]  = '{1, 0, 32'd1035, 32'd0,           1, 0, 32'hA5A5A5A5, 0, 32'd2,  2,  1};
        vecs[8]  = '{1, 0, 32'd1040, 32'd0,           0, 1, 32'd0,        0, 32'd4, 16, 15};
        vecs[9]  = '{0, 1, 32'd1276, 32'hCAFEF00D,    1, 0, 32'd0,        1, 32'd63, 2,  1};
        vecs[10] = '{1, 0, 32'd1276, 32'd0,           4, 0, 32'hCAFEF00D, 0, 32'd63, 5,  4};
        vecs[11] = '{0, 1, 32'd1280, 32'h11111111,    1, 1, 32'd0,        0, 32'd0,  1,  0};
        vecs[12] = '{1, 0, 32'd1276, 32'd0,           1, 0, 32'hCAFEF00D, 0, 32'd63, 2,  1};
        vecs[13] = '{0, 1, 32'd1028, 32'h5555AAAA,    0, 1, 32'hCAFEF00D, 1, 32'd1, 16, 15};

        for (int i = 0; i < 64; i++) model[i] = $urandom;
        model[3] = 32'hDEADBEEF;

        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        applyStimulus(0, 0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_ready", ready, 1);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_rdata", rdata_out, 0);

        for (int i = 0; i < 14; i++) begin
            doAccess(vecs[i], 0, none);
            @(negedge clk);
            checkOutput("after_done_err", err, 0);
            checkOutput("after_done_ready", ready, 1);
        end

        // Back-to-back: the next read is presented in DONE and must only
        // start from the IDLE cycle that follows.
        rd_a = '{1, 0, 32'd1036, 32'd0, 1, 0, 32'hDEADBEEF, 0, 32'd3, 2, 1};
        rd_b = '{1, 0, 32'd1028, 32'd0, 2, 0, 32'h12345678, 0, 32'd1, 3, 2};
        doAccess(rd_a, 1, rd_b);
        doAccess(rd_b, 0, none);

        // Read timeout followed by an ack arriving in IDLE.
        doAccess(vecs[8], 0, none);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checkOutput("late_ack_mem_req", mem_req, 0);
        checkOutput("late_ack_ready", ready, 1);
        checkOutput("late_ack_rdata", rdata_out, 0);
        checkOutput("late_ack_err", err, 0);

        // Reset in the second WAIT cycle of a read.
        doAccess(vecs[12], 0, none);
        @(negedge clk);
        applyStimulus(1, 0, 32'd1036, 32'd0);
        @(negedge clk);
        checkOutput("mid_wait1_req", mem_req, 1);
        @(negedge clk);
        checkOutput("mid_wait2_req", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_mem_req", mem_req, 0);
        checkOutput("mid_rst_rdata", rdata_out, 0);
        checkOutput("mid_rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 32'd0, 32'd0);
        #1;
        checkOutput("mid_rst_ready", ready, 1);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checkOutput("post_rst_ack_req", mem_req, 0);
        checkOutput("post_rst_ack_ready", ready, 1);
        checkOutput("post_rst_ack_rdata", rdata_out, 0);
        checkOutput("post_rst_ack_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
